prog_stream_tx: RTL and testbench

Program-image streamer that drives the processor's byte-wide load port. A host fills a small on-block image buffer, then pulses `go`. The block emits a header byte (the program's start address), then the program bytes in address order, over a valid/ready byte interface, and finally pulses `start` to launch execution. It sits between the host/test harness and the processor's `data_in`/`start` inputs, and is the transmit end of the processor's load protocol.

---
 rtl/prog_stream_pkg.sv | 5 +
 rtl/prog_image_ram.sv | 19 +
 rtl/prog_stream_tx.sv | 78 +++++++
 tb/tb_prog_stream_tx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/prog_stream_pkg.sv
// prog_stream_pkg: shared state encoding and byte width for the program-image streamer
package prog_stream_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, HDR, BODY, CSUM, STRT} state_t;
endpackage

// File: rtl/prog_image_ram.sv
// prog_image_ram: DEPTHx8 register array, one write port, asynchronous read, contents survive reset
module prog_image_ram
  import prog_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);
  logic [BYTE_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/prog_stream_tx.sv
// prog_stream_tx: streams header, image bytes and a start pulse to the processor load port
// Optional trailing XOR checksum byte enabled by defining PROG_STREAM_CSUM_EN.
module prog_stream_tx
  import prog_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [BYTE_W-1:0] base_addr,
  input  logic [AW:0]       len,
  input  logic              go,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              start,
  output logic              busy
);
  localparam logic [AW:0] DMAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
`ifdef PROG_STREAM_CSUM_EN
  localparam state_t POST = CSUM;
`else
  localparam state_t POST = STRT;
`endif
  state_t state, state_d;
  logic [BYTE_W-1:0] base_q, rd, csum;
  logic [AW:0] len_q, idx;
  logic xfer, last, launch;
  assign valid = state == HDR || state == BODY || state == CSUM;
  assign start = state == STRT;
  assign busy = state != IDLE;
  assign xfer = valid && ready;
  assign last = idx == len_q - ONE;
  assign launch = state == IDLE && go;
  assign data_out = state == HDR ? base_q : state == BODY ? rd : state == CSUM ? csum : '0;
  prog_image_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk), .we(wr_en && !busy), .waddr(wr_addr), .wdata(wr_data),
    .raddr(idx[AW-1:0]), .rdata(rd)
  );
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = go ? HDR : IDLE;
      HDR: state_d = xfer ? (len_q == '0 ? POST : BODY) : HDR;
      BODY: state_d = xfer && last ? POST : BODY;
      CSUM: state_d = xfer ? STRT : CSUM;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      base_q <= '0;
      len_q <= '0;
      idx <= '0;
    end else begin
      state <= state_d;
      if (launch) begin
        base_q <= base_addr;
        len_q <= len > DMAX ? DMAX : len;
        idx <= '0;
      end else if (state == BODY && xfer) idx <= idx + ONE;
    end
`ifdef PROG_STREAM_CSUM_EN
  // header and body bytes fold in as they transfer; CSUM then presents the result
  always_ff @(posedge clk or posedge rst)
    if (rst) csum <= '0;
    else if (launch) csum <= '0;
    else if ((state == HDR || state == BODY) && xfer) csum <= csum ^ data_out;
`else
  assign csum = '0;
`endif
endmodule

// File: tb/tb_prog_stream_tx.sv
// tb_prog_stream_tx: randomized scoreboard bench for prog_stream_tx against a queue-based reference
module tb_prog_stream_tx;
  localparam int START_TOK = 256;
  logic clk = 0, rst = 1, wr_en = 0, go = 0, ready = 1;
  logic [3:0] wr_addr = 0;
  logic [7:0] wr_data = 0, base_addr = 0;
  logic [4:0] len = 0;
  logic [7:0] data_out;
  logic valid, start, busy;
  logic [7:0] img [16];
  int exp_q[$];
  int compared = 0, mismatched = 0;
  logic held = 0;
  logic [7:0] held_d = 0;

  prog_stream_tx dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .base_addr(base_addr), .len(len), .go(go), .data_out(data_out), .valid(valid),
    .ready(ready), .start(start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic pop_check(input string nm, input int act);
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: got %0h, expected nothing (scoreboard empty)", nm, act);
    end else check(nm, act, exp_q.pop_front());
  endtask

  // monitor: transfers happen on the next rising edge when valid && ready here
  always @(negedge clk) begin
    if (rst) held = 0;
    else begin
      if (held) check("hold", {valid, data_out}, {1'b1, held_d});
      if (valid && ready) pop_check("byte", data_out);
      if (start) begin
        pop_check("start", START_TOK);
        check("start_novalid", valid, 0);
      end
      held = valid && !ready;
      held_d = data_out;
    end
  end

  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1;
    wr_addr = a[3:0];
    wr_data = d;
    img[a] = d;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  // mode: 0 ready=1, 1 random ready, 2 stall on 0x0a, 3 go+write mid-body,
  // 4 reset mid-body, 5 write addr0 together with go
  task automatic run(input logic [7:0] b, input int l, input int mode);
    int n;
    int drops;
    logic [7:0] cs;
    logic [7:0] nd;
    nd = 8'($urandom);
    if (mode == 5) begin
      wr_en = 1;
      wr_addr = 0;
      wr_data = nd;
      img[0] = nd;
    end
    n = l > 16 ? 16 : l;
    cs = b;
    exp_q.push_back(b);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(img[i]);
      cs ^= img[i];
    end
`ifdef PROG_STREAM_CSUM_EN
    exp_q.push_back(cs);
`endif
    exp_q.push_back(START_TOK);
    base_addr = b;
    len = l[4:0];
    go = 1;
    ready = 1;
    @(posedge clk); #1;
    go = 0;
    wr_en = 0;
    base_addr = 8'($urandom);
    len = 5'($urandom);
    check("launch", {busy, valid, data_out}, {2'b11, b});
    drops = 0;
    for (int c = 0; c < 300; c++) begin
      if (!busy && exp_q.size() == 0) break;
      ready = 1;
      if (mode == 1) ready = $urandom_range(0, 3) != 0;
      if (mode == 2 && valid && data_out == 8'h0a && drops < 3) begin
        ready = 0;
        drops++;
      end
      if (mode == 3 && c == 3) begin
        go = 1;
        wr_en = 1;
        wr_addr = 1;
        wr_data = 8'hff;
      end
      if (mode == 4 && c == 3) begin
        rst = 1;
        #1;
        check("rst_async", {valid, busy, start, data_out}, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 0;
        return;
      end
      @(posedge clk); #1;
      go = 0;
      wr_en = 0;
    end
    check("done", {busy, exp_q.size() != 0}, 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset", {valid, busy, start, data_out}, 0);
    rst = 0;
    @(posedge clk); #1;
    wr(0, 8'h01); wr(1, 8'h0a); wr(2, 8'h02); wr(3, 8'ha0); wr(4, 8'h03);
    for (int a = 5; a < 16; a++) wr(a, 8'($urandom));
    run(8'h55, 5, 0);
    run(8'h55, 5, 2);
    run(8'h55, 0, 0);
    run(8'h55, 5, 3);
    run(8'h55, 5, 0);
    run(8'h55, 5, 4);
    run(8'h55, 5, 0);
    run(8'h55, 20, 0);
    run(8'h3c, 16, 5);
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 3)) wr($urandom_range(0, 15), 8'($urandom));
      run(8'($urandom), $urandom_range(0, 31), $urandom_range(0, 1));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
